// File: rtl/eth_fcs_inserter.sv
// eth_fcs_inserter: transmit-side frame sequencer between the packet buffer
// and the MAC byte serializer. Frame bytes pass straight through. Short
// frames are padded with zeros up to MIN_FRAME bytes. The 4-byte Ethernet
// FCS is then appended, and an IFG_CYCLES-cycle gap follows before the
// next frame is accepted.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_data/valid/last    frame bytes from the packet buffer; in_ready back
//   out_data/valid/last   bytes to the serializer; out_ready back
//                         (out_last marks the final FCS byte)
//   frame_done            one-cycle pulse after the final FCS byte transfer
//   frame_len             payload+pad length of the last completed frame
//
// Handshake: on either side a byte moves on a cycle where valid && ready
// are both high. Once raised, valid and data stay stable until that
// transfer happens.

// crc32: byte-wide Ethernet CRC-32 engine (polynomial 0x04C11DB7).
// The register is kept MSB-first, and each byte is fed LSB-first, which
// is the order the wire sees. The register presets to all ones on rst.
module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q, crc_d, crc_step;

  always_comb begin
    crc_step = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (crc_step[31] ^ data[i]) crc_step = {crc_step[30:0], 1'b0} ^ POLY;
      else                        crc_step = {crc_step[30:0], 1'b0};
    end
    crc_d = en ? crc_step : crc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 32'hFFFF_FFFF;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

module eth_fcs_inserter #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [15:0] frame_len
);
  typedef enum logic [1:0] {S_DATA, S_PAD, S_FCS, S_GAP} state_t;

  localparam logic [15:0] MIN_L    = 16'(MIN_FRAME);
  localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        frame_done_q, frame_done_d;

  logic        crc_en, crc_clear;
  logic [7:0]  crc_byte;
  logic [31:0] crc;
  logic [15:0] cnt_inc;
  logic [7:0]  crc_sel, fcs_byte;

  crc32 u_crc (
    .clk  (clk),
    .rst  (reset | crc_clear),
    .en   (crc_en),
    .data (crc_byte),
    .crc  (crc)
  );

  // Byte counter saturates so frames longer than 64 KiB still complete.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // FCS byte k is the complement of crc byte (3-k) with its bits reversed:
  // bit i of the output is ~crc[31-8k-i].
  always_comb begin
    case (k_q)
      2'd0:    crc_sel = crc[31:24];
      2'd1:    crc_sel = crc[23:16];
      2'd2:    crc_sel = crc[15:8];
      default: crc_sel = crc[7:0];
    endcase
    for (int i = 0; i < 8; i++) fcs_byte[i] = ~crc_sel[7-i];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    gap_d        = gap_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = 8'h00;
    out_last     = 1'b0;
    crc_en       = 1'b0;
    crc_byte     = 8'h00;
    crc_clear    = 1'b0;

    case (state_q)
      S_DATA: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        crc_byte  = in_data;
        if (in_valid && out_ready) begin
          crc_en = 1'b1;
          cnt_d  = cnt_inc;
          if (in_last) begin
            k_d     = 2'd0;
            state_d = (cnt_inc < MIN_L) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          crc_en = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == MIN_L) state_d = S_FCS;
        end
      end
      S_FCS: begin
        out_valid = 1'b1;
        out_data  = fcs_byte;
        out_last  = (k_q == 2'd3);
        if (out_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            // Clear the crc on the same edge the last FCS byte leaves.
            crc_clear    = 1'b1;
            frame_len_d  = cnt_q;
            cnt_d        = 16'd0;
            frame_done_d = 1'b1;
            gap_d        = 16'd0;
            state_d      = (IFG_CYCLES == 0) ? S_DATA : S_GAP;
          end
        end
      end
      S_GAP: begin
        // Counts clock cycles regardless of out_ready.
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) state_d = S_DATA;
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_DATA;
      cnt_q        <= 16'd0;
      k_q          <= 2'd0;
      gap_q        <= 16'd0;
      frame_len_q  <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      gap_q        <= gap_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
endmodule
